// File: rtl/sy_fifo_ctrl.sv
// Synchronous FIFO controller driving an sy_dpram: pointers, occupancy, flags and RAM strobes.
// Optional sticky overflow/underflow outputs are compiled in with `define SY_FIFO_ERR_FLAG_EN.
module sy_fifo_ctrl #(
  parameter int WD = 8,
  parameter int DP = 16,
  parameter int AD = clogb2(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [WD-1:0] wr_data,
  input  logic          rd_en,
  output logic          full,
  output logic          empty,
  output logic [AD:0]   count,
  output logic          rd_valid,
  output logic          ram_cs_n,
  output logic          ram_wr_n,
  output logic          ram_rd_n,
  output logic [WD-1:0] ram_din_b,
  output logic [AD-1:0] ram_addr_b,
  output logic [AD-1:0] ram_addr_a
`ifdef SY_FIFO_ERR_FLAG_EN
  ,
  output logic          ovf,
  output logic          udf
`endif
);

  function automatic int clogb2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  localparam logic [AD:0] DP_CNT  = (AD+1)'(DP);
  localparam logic [AD:0] ONE_CNT = (AD+1)'(1);

  logic [AD:0] wptr;
  logic [AD:0] rptr;
  logic [AD:0] count_next;
  logic        wr_go;
  logic        rd_go;

  // Accepts use the registered flags, so a same-cycle push+pop on empty only writes.
  assign wr_go = wr_en & ~full;
  assign rd_go = rd_en & ~empty;

  assign ram_wr_n   = ~wr_go;
  assign ram_rd_n   = ~rd_go;
  assign ram_cs_n   = ~rst_n;
  assign ram_din_b  = wr_data;
  assign ram_addr_b = wptr[AD-1:0];
  assign ram_addr_a = rptr[AD-1:0];

  always_comb begin
    count_next = count;
    case ({wr_go, rd_go})
      2'b10:   count_next = count + ONE_CNT;
      2'b01:   count_next = count - ONE_CNT;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      rd_valid <= 1'b0;
    end else begin
      if (wr_go) wptr <= wptr + ONE_CNT;
      if (rd_go) rptr <= rptr + ONE_CNT;
      count    <= count_next;
      full     <= (count_next == DP_CNT);
      empty    <= (count_next == '0);
      rd_valid <= rd_go;
    end
  end

  // Wrap bits are kept for debug visibility; the flags are derived from count.
  logic unused_wrap;
  assign unused_wrap = wptr[AD] ^ rptr[AD];

`ifdef SY_FIFO_ERR_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_en && full)  ovf <= 1'b1;
      if (rd_en && empty) udf <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_sy_fifo_ctrl.sv
// Scoreboard bench for sy_fifo_ctrl with a behavioural RAM and a queue-based FIFO reference.
module tb_sy_fifo_ctrl;
  localparam int WD = 8;
  localparam int DP = 16;
  localparam int AD = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [WD-1:0] wr_data;
  logic          rd_en;
  logic          full, empty, rd_valid;
  logic [AD:0]   count;
  logic          ram_cs_n, ram_wr_n, ram_rd_n;
  logic [WD-1:0] ram_din_b;
  logic [AD-1:0] ram_addr_b, ram_addr_a;
`ifdef SY_FIFO_ERR_FLAG_EN
  logic          ovf, udf;
`endif

  sy_fifo_ctrl #(.WD(WD), .DP(DP)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .full(full), .empty(empty), .count(count), .rd_valid(rd_valid),
    .ram_cs_n(ram_cs_n), .ram_wr_n(ram_wr_n), .ram_rd_n(ram_rd_n),
    .ram_din_b(ram_din_b), .ram_addr_b(ram_addr_b), .ram_addr_a(ram_addr_a)
`ifdef SY_FIFO_ERR_FLAG_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for sy_dpram.
  logic [WD-1:0] mem [DP];
  logic [WD-1:0] dout_a;
  always @(posedge clk) begin
    if (!ram_cs_n) begin
      if (!ram_wr_n) mem[ram_addr_b] <= ram_din_b;
      if (!ram_rd_n) dout_a <= mem[ram_addr_a];
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference: FIFO contents as a queue, pointers as plain counters modulo DP.
  logic [WD-1:0] mq[$];
  logic [WD-1:0] exp_q[$];
  int m_w = 0, m_r = 0;
  bit m_ovf = 0, m_udf = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every rd_valid cycle must present the oldest outstanding popped word.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL rd_data: got %0h with no pop outstanding", dout_a);
      end else begin
        chk("rd_data", 32'(dout_a), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic model_clear();
    mq.delete();
    exp_q.delete();
    m_w = 0;
    m_r = 0;
    m_ovf = 0;
    m_udf = 0;
  endtask

  // One clock cycle of stimulus; called and returning at posedge+1.
  task automatic step(input bit w, input bit r, input logic [WD-1:0] d);
    bit m_full, m_empty, wg, rg;
    wr_en = w;
    rd_en = r;
    wr_data = d;
    m_full  = (mq.size() == DP);
    m_empty = (mq.size() == 0);
    wg = w && !m_full;
    rg = r && !m_empty;
    #1;
    chk("ram_wr_n", 32'(ram_wr_n), 32'(!wg));
    chk("ram_rd_n", 32'(ram_rd_n), 32'(!rg));
    chk("ram_addr_b", 32'(ram_addr_b), 32'(m_w % DP));
    chk("ram_addr_a", 32'(ram_addr_a), 32'(m_r % DP));
    if (w && m_full) m_ovf = 1;
    if (r && m_empty) m_udf = 1;
    if (rg) begin
      exp_q.push_back(mq.pop_front());
      m_r++;
    end
    if (wg) begin
      mq.push_back(d);
      m_w++;
    end
    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(mq.size()));
    chk("full", 32'(full), 32'(mq.size() == DP));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("rd_valid", 32'(rd_valid), 32'(rg));
`ifdef SY_FIFO_ERR_FLAG_EN
    chk("ovf", 32'(ovf), 32'(m_ovf));
    chk("udf", 32'(udf), 32'(m_udf));
`endif
  endtask

  // Asynchronous reset taken between edges; called and returning at posedge+1.
  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_cs_n", 32'(ram_cs_n), 32'd1);
    model_clear();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("run_cs_n", 32'(ram_cs_n), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    wr_data = '0;
    @(posedge clk);
    #1;
    do_reset();

    // Fill to full, then a dropped push while full.
    for (int i = 1; i <= DP; i++) step(1, 0, 8'(i));
    step(1, 0, 8'hAA);
    // Drain with back-to-back pops, then a dropped pop on empty.
    for (int i = 0; i < DP; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Steady push+pop at occupancy 3; pointers wrap past DP-1.
    for (int i = 0; i < 3; i++) step(1, 0, 8'($urandom));
    for (int i = 0; i < 40; i++) step(1, 1, 8'($urandom));
    for (int i = 0; i < 3; i++) step(0, 1, 8'h00);

    // Push and pop together while empty: only the push is accepted.
    step(1, 1, 8'h5C);
    step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    // Randomised traffic in phases biased towards filling and draining.
    for (int ph = 0; ph < 6; ph++) begin
      for (int i = 0; i < 60; i++) begin
        bit w, r;
        w = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 75 : 30));
        r = ($urandom_range(0, 99) < ((ph % 2 == 0) ? 30 : 75));
        step(w, r, 8'($urandom));
      end
    end

    // Reset in the middle of a stream, then confirm normal operation resumes.
    for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom));
    step(0, 1, 8'h00);
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h30 + i));
    for (int i = 0; i < 5; i++) step(0, 1, 8'h00);
    step(0, 0, 8'h00);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sy_fifo_ctrl.md
# sy_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the `sy_dpram` simple dual-port RAM and turns it into a first-in/first-out buffer. It accepts push/pop requests from the producer and consumer, generates the RAM's active-low strobes and its A/B addresses, and tracks occupancy. It also reports the full, empty and read-valid status. Read data is taken straight from the RAM's `dout_a`; this block supplies the matching valid strobe.

## Interface
Parameters:
- `WD`, 8: data width; must equal the RAM's `WD`.
- `DP`, 16: FIFO depth; a power of two, ≥ 2; must equal the RAM's `DP`.
- `AD`, clogb2(DP): address width, computed with the codebase's `clogb2` function.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `wr_en` in 1: push request.
- `wr_data` in WD: push data.
- `rd_en` in 1: pop request.
- `full` out 1: registered; occupancy equals DP.
- `empty` out 1: registered; occupancy is 0.
- `count` out AD+1: registered occupancy, 0..DP.
- `rd_valid` out 1: registered; the RAM `dout_a` holds popped data this cycle.
- `ram_cs_n` out 1: to RAM `cs_n`.
- `ram_wr_n` out 1: to RAM `wr_n`.
- `ram_rd_n` out 1: to RAM `rd_n`.
- `ram_din_b` out WD: to RAM `din_b`; equals `wr_data`.
- `ram_addr_b` out AD: to RAM `addr_b`; write address.
- `ram_addr_a` out AD: to RAM `addr_a`; read address.

## Operation
- Pointers: `wptr` and `rptr` are each AD+1 bits. The MSB is a wrap bit and the low AD bits are the RAM address. `ram_addr_b = wptr[AD-1:0]` and `ram_addr_a = rptr[AD-1:0]`.
- Write accept: `wr_go = wr_en & ~full`. Read accept: `rd_go = rd_en & ~empty`. Both use the registered flags.
- RAM strobes are combinational so the RAM samples them at the same edge:
  - `ram_wr_n = ~wr_go`
  - `ram_rd_n = ~rd_go`
  - `ram_cs_n = ~rst_n`
- `ram_cs_n` is held low whenever the block is out of reset. With `cs_n` high the RAM forces `dout_a` to X, so it must not be deasserted during operation.
- On `wr_go`, `wptr` increments by 1. On `rd_go`, `rptr` increments by 1. Both wrap naturally modulo 2·DP.
- `count_next = count + wr_go − rd_go`. The flags are registered from the next value: `full <= (count_next == DP)` and `empty <= (count_next == 0)`.
- Push when full: the write is dropped; the pointer and RAM contents are unchanged.
- Pop when empty: the pop is dropped and `rd_valid` stays low.
- Simultaneous push and pop:
  - Not full and not empty: both are accepted and `count` is unchanged.
  - Empty: only the push is accepted.
  - Full: only the pop is accepted.
- Read-after-write to the same address in the same cycle cannot occur, because a pop is refused when empty.
- Between pops, `dout_a` holds the last popped word.

## Timing
- Reset values (asynchronous, take effect immediately on `rst_n` low):
  - `wptr = 0`, `rptr = 0`, `count = 0`
  - `empty = 1`, `full = 0`, `rd_valid = 0`
  - `ram_cs_n = 1`
- Reset taken mid-operation discards all contents; no RAM access occurs while `rst_n` is low.
- Write latency: data pushed at edge N can be popped with `rd_en` in cycle N+1. At that point `empty` has deasserted after edge N.
- Read latency: a pop accepted at edge N gives `rd_valid = 1` and valid `dout_a` in cycle N+1, for exactly one cycle per accepted pop.
- Back-to-back pops give one word per cycle, with `rd_valid` held high continuously.
- Flag update: `full`, `empty` and `count` reflect all accepted operations of edge N in the cycle after edge N.

## Configuration
- Macro `SY_FIFO_ERR_FLAG_EN`.
- When defined, two extra output ports are compiled in, both reset to 0 and cleared only by reset:
  - `ovf` out 1: sticky; set on the cycle after a push request occurs while `full`.
  - `udf` out 1: sticky; set on the cycle after a pop request occurs while `empty`.
- When undefined, these ports and their logic are absent. Dropped requests are silently ignored, with identical data-path behaviour.

## Test plan
- Reset with `rst_n=0` mid-stream, then release → `empty=1`, `full=0`, `count=0`, `rd_valid=0`, `ram_cs_n=1` during reset.
- Push 0x01..0x10 (DP=16), then pop 16 times → `full=1` after the 16th push; data pops 0x01..0x10 in order with `rd_valid` high for 16 consecutive cycles; `empty=1` afterwards.
- With the FIFO full, push 0xAA → dropped; `count=16` and the next pop returns 0x01. With `SY_FIFO_ERR_FLAG_EN` defined, `ovf=1`.
- With the FIFO empty, pop → `rd_valid` stays 0 and the pointers are unchanged. With `SY_FIFO_ERR_FLAG_EN` defined, `udf=1`.
- Simultaneous push and pop for 40 cycles at `count=3` → `count` stays 3; the addresses wrap past 15 to 0; the output sequence equals the input sequence delayed by 3 pops.
- Simultaneous push 0x5C and pop while empty → only the write is accepted; `count=1` and `rd_valid=0`; the next pop returns 0x5C.
